// File: rtl/dot_engine_arbiter.sv
// Round-robin arbiter sharing one dot-product engine between NREQ requesters.
// One job in flight: capture the winner's operands, start the engine, return result or timeout.
module dot_engine_arbiter #(
   parameter int NREQ    = 4,
   parameter int VEC_LEN = 16,
   parameter int ELEM_W  = 8,
   parameter int RES_W   = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREQ-1:0]                 req,
   input  logic [NREQ*VEC_LEN*ELEM_W-1:0]  req_a,
   input  logic [NREQ*VEC_LEN*ELEM_W-1:0]  req_b,
   output logic [NREQ-1:0]                 grant,
   output logic [NREQ-1:0]                 resp_valid,
   output logic [RES_W-1:0]                resp_data,
   output logic                            resp_err,
   output logic                            busy,
   output logic                            eng_start,
   output logic [VEC_LEN*ELEM_W-1:0]       eng_a,
   output logic [VEC_LEN*ELEM_W-1:0]       eng_b,
   input  logic [RES_W-1:0]                eng_c,
   input  logic                            eng_done,
   output logic [15:0]                     jobs_done
);

   localparam int VW    = VEC_LEN * ELEM_W;
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [CNT_W-1:0]   tmo_cnt;
   logic               found;
   logic [PTR_W-1:0]   winner;

   // Lowest requester overall, overridden by the lowest one at or after rr_ptr.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            found  = 1'b1;
            winner = PTR_W'(i);
         end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i] && (PTR_W'(i) >= rr_ptr)) begin
            winner = PTR_W'(i);
         end
      end
   end

   assign busy       = (state != IDLE);
   assign eng_start  = (state == ISSUE);
   assign resp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         tmo_cnt   <= '0;
         grant     <= '0;
         eng_a     <= '0;
         eng_b     <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
         jobs_done <= '0;
      end else begin
         grant <= '0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant  <= NREQ'(1) << winner;
                  eng_a  <= req_a[int'(winner)*VW +: VW];
                  eng_b  <= req_b[int'(winner)*VW +: VW];
                  owner  <= winner;
                  rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // A completion in the last allowed cycle still counts as success.
               if (eng_done) begin
                  resp_data <= eng_c;
                  resp_err  <= 1'b0;
                  state     <= RESP;
               end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               jobs_done <= jobs_done + 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_engine_arbiter.sv
// Randomized bench for dot_engine_arbiter: a default-timeout instance and a TIMEOUT=16 instance share stimulus.
module tb_dot_engine_arbiter;

   localparam int NREQ  = 4;
   localparam int VW    = 128;
   localparam int TMO_A = 4096;
   localparam int TMO_B = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [511:0] req_a, req_b;
   logic [15:0]  eng_c;
   logic         eng_done;
   logic         sel;

   logic [3:0]   a_grant, a_resp_valid, b_grant, b_resp_valid;
   logic [15:0]  a_resp_data, b_resp_data, a_jobs_done, b_jobs_done;
   logic         a_resp_err, a_busy, a_eng_start, b_resp_err, b_busy, b_eng_start;
   logic [127:0] a_eng_a, a_eng_b, b_eng_a, b_eng_b;

   logic [3:0]   grant, resp_valid;
   logic [15:0]  resp_data, jobs_done;
   logic         resp_err, busy, eng_start;
   logic [127:0] eng_a, eng_b;

   int errors = 0;
   int checks = 0;
   int model_last;
   int model_jobs;
   int starts;
   logic [3:0] last_grant;

   always #5 clk = ~clk;

   dot_engine_arbiter u_dut_a (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .grant(a_grant), .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_err(a_resp_err),
      .busy(a_busy), .eng_start(a_eng_start), .eng_a(a_eng_a), .eng_b(a_eng_b),
      .eng_c(eng_c), .eng_done(eng_done), .jobs_done(a_jobs_done)
   );

   dot_engine_arbiter #(.TIMEOUT(TMO_B)) u_dut_b (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .grant(b_grant), .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_err(b_resp_err),
      .busy(b_busy), .eng_start(b_eng_start), .eng_a(b_eng_a), .eng_b(b_eng_b),
      .eng_c(eng_c), .eng_done(eng_done), .jobs_done(b_jobs_done)
   );

   assign grant      = sel ? b_grant      : a_grant;
   assign resp_valid = sel ? b_resp_valid : a_resp_valid;
   assign resp_data  = sel ? b_resp_data  : a_resp_data;
   assign resp_err   = sel ? b_resp_err   : a_resp_err;
   assign busy       = sel ? b_busy       : a_busy;
   assign eng_start  = sel ? b_eng_start  : a_eng_start;
   assign eng_a      = sel ? b_eng_a      : a_eng_a;
   assign eng_b      = sel ? b_eng_b      : a_eng_b;
   assign jobs_done  = sel ? b_jobs_done  : a_jobs_done;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_ops();
      for (int i = 0; i < 16; i++) begin
         req_a[i*32 +: 32] = $urandom;
         req_b[i*32 +: 32] = $urandom;
      end
   endtask

   // Next requester served is the first asking one after the last served, cyclically.
   function automatic int model_pick(input logic [3:0] r);
      int w;
      w = -1;
      for (int i = 1; i <= NREQ; i++) begin
         if (w < 0 && r[(model_last + i) % NREQ]) w = (model_last + i) % NREQ;
      end
      return w;
   endfunction

   task automatic do_reset();
      rst = 1'b1; req = '0; eng_done = 1'b0; eng_c = '0;
      step(); step();
      rst = 1'b0;
      model_last = NREQ - 1;
      model_jobs = 0;
   endtask

   // One complete job; lat = cycles from eng_start to eng_done, beyond the timeout means no eng_done.
   task automatic run_job(input logic [3:0] r, input int lat, input bit hold, input bit corrupt,
                          input logic [15:0] val);
      int w, tmo, n;
      bit early;
      logic [127:0] ea, eb;
      logic [3:0] oh;
      logic [15:0] exp_data;
      tmo = sel ? TMO_B : TMO_A;
      w = model_pick(r);
      oh = 4'b1 << w;
      early = (lat <= tmo);
      n = early ? lat : tmo;
      exp_data = early ? val : 16'h0;
      req = r; eng_done = 1'b0;
      randomize_ops();
      ea = req_a[w*VW +: VW];
      eb = req_b[w*VW +: VW];
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
      step();
      last_grant = grant;
      if (eng_start === 1'b1) starts++;
      checks++;
      if ({grant, eng_start, busy} !== {oh, 1'b1, 1'b1}) begin
         errors++; $display("FAIL grant: got grant=%b start=%b busy=%b expected grant=%b start=1 busy=1", grant, eng_start, busy, oh);
      end
      checks++;
      if ({eng_a, eng_b} !== {ea, eb}) begin
         errors++; $display("FAIL capture: got a=%h b=%h expected a=%h b=%h", eng_a, eng_b, ea, eb);
      end
      model_last = w;
      if (corrupt) req_a[w*VW +: VW] = {VW{1'b1}};
      else if (!hold) randomize_ops();
      for (int k = 0; k < n; k++) begin
         eng_done = (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         eng_c = 16'($urandom);
         if (!hold) req = 4'($urandom);
         step();
         if (eng_start === 1'b1) starts++;
         checks++;
         if ({resp_valid, grant, eng_start, busy} !== {4'b0, 4'b0, 1'b0, 1'b1} || eng_a !== ea) begin
            errors++; $display("FAIL wait: got rv=%b grant=%b start=%b busy=%b a=%h expected rv=0 grant=0 start=0 busy=1 a=%h", resp_valid, grant, eng_start, busy, eng_a, ea);
         end
      end
      eng_done = early; eng_c = val;
      if (hold) req = r;
      step();
      checks++;
      if ({resp_valid, resp_data, resp_err} !== {oh, exp_data, ~early}) begin
         errors++; $display("FAIL resp: got rv=%b data=%h err=%b expected rv=%b data=%h err=%b", resp_valid, resp_data, resp_err, oh, exp_data, ~early);
      end
      checks++;
      if ({eng_a, eng_b, eng_start} !== {ea, eb, 1'b0}) begin
         errors++; $display("FAIL resp_operands: got a=%h start=%b expected a=%h start=0", eng_a, eng_start, ea);
      end
      eng_done = 1'b0;
      req = hold ? r : 4'b0;
      step();
      model_jobs++;
      checks++;
      if ({busy, resp_valid, jobs_done, resp_data} !== {1'b0, 4'b0, 16'(model_jobs), exp_data}) begin
         errors++; $display("FAIL after_resp: got busy=%b rv=%b jobs=%0d data=%h expected busy=0 rv=0 jobs=%0d data=%h", busy, resp_valid, jobs_done, resp_data, model_jobs, exp_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'hF; eng_done = 1'b1; eng_c = 16'hFFFF;
      randomize_ops();
      step(); step();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if ({grant, resp_valid, resp_data, resp_err, busy, eng_start, eng_a, eng_b, jobs_done} !== '0) begin
            errors++; $display("FAIL reset_state inst=%0d: got grant=%b rv=%b data=%h err=%b busy=%b start=%b jobs=%0d expected all 0", s, grant, resp_valid, resp_data, resp_err, busy, eng_start, jobs_done);
         end
      end
      sel = 1'b0;
      do_reset();
   endtask

   task automatic test_single();
      run_job(4'b0100, 20, 1'b0, 1'b0, 16'h1234);
   endtask

   task automatic test_round_robin();
      do_reset();
      starts = 0;
      for (int i = 0; i < 5; i++) begin
         run_job(4'b1111, $urandom_range(1, 8), (i < 4), 1'b0, 16'($urandom));
         checks++;
         if (last_grant !== (4'b1 << (i % 4))) begin
            errors++; $display("FAIL rr_order job %0d: got %b expected %b", i, last_grant, 4'b1 << (i % 4));
         end
      end
      checks++;
      if (jobs_done !== 16'd5 || starts != 5) begin
         errors++; $display("FAIL rr_totals: got jobs=%0d starts=%0d expected 5 and 5", jobs_done, starts);
      end
   endtask

   task automatic test_rr_pointer();
      do_reset();
      run_job(4'b0010, 5, 1'b0, 1'b0, 16'h0F0F);
      run_job(4'b0101, 6, 1'b1, 1'b0, 16'h1111);
      checks++;
      if (last_grant !== 4'b0100) begin errors++; $display("FAIL rr_ptr_first: got %b expected 0100", last_grant); end
      run_job(4'b0101, 4, 1'b0, 1'b0, 16'h2222);
      checks++;
      if (last_grant !== 4'b0001) begin errors++; $display("FAIL rr_ptr_second: got %b expected 0001", last_grant); end
   endtask

   task automatic test_operand_hold();
      run_job(4'b1000, 12, 1'b0, 1'b1, 16'h5A5A);
      checks++;
      if (last_grant !== 4'b1000) begin errors++; $display("FAIL hold_grant: got %b expected 1000", last_grant); end
   endtask

   task automatic test_reset_mid_job();
      do_reset();
      run_job(4'b0001, 3, 1'b0, 1'b0, 16'hBEEF);
      req = 4'b0100;
      step();
      req = 4'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      checks++;
      if ({grant, resp_valid, resp_data, resp_err, busy, eng_start, eng_a, eng_b, jobs_done} !== '0) begin
         errors++; $display("FAIL reset_mid_job: got grant=%b rv=%b data=%h err=%b busy=%b start=%b jobs=%0d expected all 0", grant, resp_valid, resp_data, resp_err, busy, eng_start, jobs_done);
      end
      rst = 1'b0;
      model_last = NREQ - 1;
      model_jobs = 0;
      run_job(4'b0010, 7, 1'b0, 1'b0, 16'h7777);
      checks++;
      if (last_grant !== 4'b0010) begin errors++; $display("FAIL post_reset_grant: got %b expected 0010", last_grant); end
   endtask

   task automatic test_timeout();
      sel = 1'b1;
      do_reset();
      run_job(4'b0001, 5, 1'b0, 1'b0, 16'hA5A5);
      run_job(4'b1000, 100, 1'b0, 1'b0, 16'hFFFF);
      step(); step(); step(); step();
      eng_done = 1'b1; eng_c = 16'hDEAD;
      step();
      eng_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({resp_valid, busy, jobs_done, resp_err} !== {4'b0, 1'b0, 16'(model_jobs), 1'b1}) begin
            errors++; $display("FAIL late_done: got rv=%b busy=%b jobs=%0d err=%b expected rv=0 busy=0 jobs=%0d err=1", resp_valid, busy, jobs_done, resp_err, model_jobs);
         end
      end
      run_job(4'b0100, TMO_B, 1'b0, 1'b0, 16'h4242);
      run_job(4'b0010, TMO_B + 1, 1'b0, 1'b0, 16'h4343);
   endtask

   task automatic test_random();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         do_reset();
         for (int j = 0; j < 15; j++) begin
            run_job(4'($urandom_range(1, 15)), $urandom_range(1, s ? 24 : 30), 1'b0,
                    ($urandom_range(0, 3) == 0), 16'($urandom));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      sel = 1'b0; rst = 1'b1; req = '0; eng_done = 1'b0; eng_c = '0; req_a = '0; req_b = '0;
      last_grant = '0; starts = 0; model_last = NREQ - 1; model_jobs = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_rr_pointer();
      test_operand_hold();
      test_reset_mid_job();
      test_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
